ins_loader: RTL and testbench

- Writable instruction store that the CPU reads by PC.
- Also acts as the writer side of that store: a byte-stream program loader that fills the 16-entry x 16-bit instruction array.
- Sits between an external host byte link and the CPU fetch path. The CPU sees the same zero-latency PC -> instruction read as a ROM, but program contents are set at run time.

---
 rtl/ins_loader.sv | 120 ++++++++++++
 tb/tb_ins_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ins_loader.sv
// Writable 16x16 instruction store: the CPU reads it by PC with zero latency, and a
// host byte stream loads it (high byte first), then pads any unloaded entries with FILL_INS.
module ins_loader #(
   parameter int          DEPTH    = 16,
   parameter int          ADDR_W   = 4,
   parameter logic [15:0] FILL_INS = 16'h0300
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [7:0]        BYTE_IN,
   input  logic              BYTE_VALID,
   input  logic              BYTE_LAST,
   output logic              BYTE_READY,
   input  logic [ADDR_W-1:0] PC,
   output logic [15:0]       RES_INS,
   output logic              LOADING,
   output logic              DONE,
   output logic [ADDR_W:0]   WORDS,
   output logic [2:0]        DBG_STATE
);

   // Handshake: a byte moves on a rising CLK edge where BYTE_VALID && BYTE_READY;
   // BYTE_READY is high only while waiting for a high or low byte.
   typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_FILL, S_DONE} state_t;

   localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] END_A  = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   addr_q, addr_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       mem_q [DEPTH];
   logic              wr_en;
   logic [15:0]       wr_data;
   logic              xfer;

   assign BYTE_READY = (state_q == S_HI) || (state_q == S_LO);
   assign LOADING    = BYTE_READY || (state_q == S_FILL);
   assign DONE       = (state_q == S_DONE);
   assign WORDS      = words_q;
   assign DBG_STATE  = state_q;
   assign xfer       = BYTE_VALID && BYTE_READY;

   // While loading, the CPU must not see half-written contents.
   assign RES_INS = LOADING ? FILL_INS : mem_q[PC];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      words_d = words_q;
      hi_d    = hi_q;
      wr_en   = 1'b0;
      wr_data = FILL_INS;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d = S_HI;
               addr_d  = '0;
               words_d = '0;
            end
         end
         S_HI: begin
            if (xfer) begin
               if (BYTE_LAST) begin
                  // A program cannot end on a high byte: drop it and pad from here.
                  state_d = S_FILL;
               end else begin
                  hi_d    = BYTE_IN;
                  state_d = S_LO;
               end
            end
         end
         S_LO: begin
            if (xfer) begin
               wr_en   = 1'b1;
               wr_data = {hi_q, BYTE_IN};
               words_d = words_q + 1'b1;
               addr_d  = addr_q + 1'b1;
               if (BYTE_LAST || (addr_q == LAST_A)) state_d = S_FILL;
               else                                  state_d = S_HI;
            end
         end
         S_FILL: begin
            if (addr_q == END_A) begin
               state_d = S_DONE;
            end else begin
               wr_en  = 1'b1;
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_A) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         words_q <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         hi_q    <= hi_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL_INS;
      end else if (wr_en) begin
         mem_q[addr_q[ADDR_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_ins_loader.sv
// Randomized bench for ins_loader: sessions are checked against a word-list model
// of the final store contents, word count and padding duration.
module tb_ins_loader;

   localparam int          DEPTH    = 16;
   localparam int          ADDR_W   = 4;
   localparam logic [15:0] FILL_INS = 16'h0300;

   logic              CLK;
   logic              RST_N;
   logic              START;
   logic [7:0]        BYTE_IN;
   logic              BYTE_VALID;
   logic              BYTE_LAST;
   logic              BYTE_READY;
   logic [ADDR_W-1:0] PC;
   logic [15:0]       RES_INS;
   logic              LOADING;
   logic              DONE;
   logic [ADDR_W:0]   WORDS;
   logic [2:0]        DBG_STATE;

   int n_checks;
   int n_errors;

   logic [15:0] prog    [DEPTH];
   logic [15:0] exp_mem [DEPTH];

   ins_loader dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .START      (START),
      .BYTE_IN    (BYTE_IN),
      .BYTE_VALID (BYTE_VALID),
      .BYTE_LAST  (BYTE_LAST),
      .BYTE_READY (BYTE_READY),
      .PC         (PC),
      .RES_INS    (RES_INS),
      .LOADING    (LOADING),
      .DONE       (DONE),
      .WORDS      (WORDS),
      .DBG_STATE  (DBG_STATE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One PC per cycle; caller is at a negedge and the store is stable.
   task automatic sweep(input string tag);
      for (int p = 0; p < DEPTH; p++) begin
         PC = ADDR_W'(p);
         #1;
         check(tag, RES_INS, exp_mem[p]);
         @(negedge CLK);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input int gap_max);
      bit ok;
      repeat ($urandom_range(0, gap_max)) @(negedge CLK);
      BYTE_IN    = b;
      BYTE_LAST  = last;
      BYTE_VALID = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (BYTE_READY) begin
            @(posedge CLK);
            ok = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      @(negedge CLK);
      BYTE_VALID = 1'b0;
      BYTE_LAST  = 1'b0;
      BYTE_IN    = 8'($urandom);
      if (!ok) check("byte_timeout", 0, 1);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Full session: n words from prog[], optional bad high byte with LAST at the end.
   task automatic run_session(input int n, input bit use_last, input bit proto_err,
                              input int gap_max, input bit poke);
      int cycles;
      int exp_cycles;
      pulse_start();
      check("start_loading", LOADING, 1);
      check("start_words", WORDS, 0);
      check("start_done", DONE, 0);
      for (int i = 0; i < n; i++) begin
         if (poke && $urandom_range(0, 2) == 0) begin
            PC = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            check("poke_res_ins", RES_INS, FILL_INS);
            pulse_start();
            check("poke_words", WORDS, i);
         end
         send_byte(prog[i][15:8], 1'b0, gap_max);
         send_byte(prog[i][7:0], use_last && !proto_err && (i == n - 1), gap_max);
      end
      if (proto_err) send_byte(8'($urandom), 1'b1, gap_max);
      cycles = 0;
      while (!DONE && cycles < 40) begin
         @(negedge CLK);
         cycles++;
      end
      exp_cycles = (n == DEPTH) ? 1 : DEPTH - n;
      check("fill_cycles", cycles, exp_cycles);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < n) ? prog[i] : FILL_INS;
      check("done", DONE, 1);
      check("loading_after", LOADING, 0);
      check("ready_after", BYTE_READY, 0);
      check("words", WORDS, n);
      sweep("res_ins");
   endtask

   initial begin
      int n;
      n_checks   = 0;
      n_errors   = 0;
      RST_N      = 1'b0;
      START      = 1'b0;
      BYTE_IN    = 8'h00;
      BYTE_VALID = 1'b0;
      BYTE_LAST  = 1'b0;
      PC         = '0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < DEPTH; i++) exp_mem[i] = FILL_INS;
      check("rst_loading", LOADING, 0);
      check("rst_done", DONE, 0);
      check("rst_words", WORDS, 0);
      check("rst_ready", BYTE_READY, 0);
      sweep("rst_res_ins");

      // Short program ending on LAST.
      prog[0] = 16'h0206; prog[1] = 16'h021D; prog[2] = 16'h0021;
      run_session(3, 1'b1, 1'b0, 0, 1'b0);

      // Full 16 words, no LAST, gap-free then with random gaps.
      for (int i = 0; i < DEPTH; i++) prog[i] = {8'(i), ~8'(i)};
      run_session(DEPTH, 1'b0, 1'b0, 0, 1'b0);
      check("word15", exp_mem[15], 16'h0FF0);
      run_session(DEPTH, 1'b0, 1'b0, 3, 1'b0);

      // Held BYTE_VALID while not ready must not consume anything.
      BYTE_VALID = 1'b1;
      BYTE_IN    = 8'hA5;
      repeat (4) @(negedge CLK);
      BYTE_VALID = 1'b0;
      check("hold_words", WORDS, DEPTH);
      check("hold_done", DONE, 1);
      sweep("hold_res_ins");

      // Random programs, some with a bad trailing high byte, with mid-session pokes.
      for (int s = 0; s < 6; s++) begin
         bit perr;
         perr = ($urandom_range(0, 2) == 0);
         n = perr ? $urandom_range(0, DEPTH - 1) : $urandom_range(1, DEPTH);
         for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
         run_session(n, 1'b1, perr, 2, 1'b1);
      end

      // Reset in the middle of a load.
      for (int i = 0; i < DEPTH; i++) prog[i] = 16'($urandom);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         send_byte(prog[i][15:8], 1'b0, 1);
         send_byte(prog[i][7:0], 1'b0, 1);
      end
      check("mid_words", WORDS, 5);
      RST_N = 1'b0;
      #1;
      check("abort_loading", LOADING, 0);
      check("abort_done", DONE, 0);
      check("abort_words", WORDS, 0);
      check("abort_ready", BYTE_READY, 0);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = FILL_INS;
      @(negedge CLK);
      sweep("abort_res_ins");
      RST_N = 1'b1;
      @(negedge CLK);
      run_session(7, 1'b1, 1'b0, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
